// File: rtl/sdram_tg_pkg.sv
// rtl/sdram_tg_pkg.sv - shared types and pattern function for the sdram traffic checker
package sdram_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_ACK,
    ST_RD_REQ,
    ST_RD_ACK,
    ST_DONE
  } tg_state_e;

  typedef enum logic [1:0] {
    MODE_SEQ      = 2'd0,
    MODE_PINGPONG = 2'd1,
    MODE_SEQ_INV  = 2'd2,
    MODE_RSVD     = 2'd3
  } tg_mode_e;

  // One 32-bit lane of the pattern; wider data buses replicate the lane with their own seed slice.
  function automatic logic [31:0] pat_gen(input logic [31:0] addr, input logic [7:0] pass,
                                          input logic [31:0] seed, input logic inv);
    logic [31:0] v;
    v = (addr ^ {pass, 24'h0}) ^ seed;
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/sdram_tg_timeout.sv
// rtl/sdram_tg_timeout.sv - loadable down-counter that flags a missing ack
module sdram_tg_timeout #(
  parameter int WIDTH = 11,
  parameter int LOAD  = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= WIDTH'(LOAD);
    end else if (tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Fires during the LOAD-th waiting cycle after the load.
  assign expired = tick && (cnt == WIDTH'(1));

endmodule

// File: rtl/sdram_traffic_checker.sv
// rtl/sdram_traffic_checker.sv - address-pattern write/read-back traffic checker for the sdram_core inport
module sdram_traffic_checker
  import sdram_tg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int PASSES = 1,
  parameter int ACK_TIMEOUT = 1024,
  parameter int ERR_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_W-1:0]     seed_i,
  output logic [DATA_W/8-1:0]   inport_wr_o,
  output logic                  inport_rd_o,
  output logic [ADDR_W-1:0]     inport_addr_o,
  output logic [DATA_W-1:0]     inport_write_data_o,
  input  logic                  inport_accept_i,
  input  logic                  inport_ack_i,
  input  logic                  inport_error_i,
  input  logic [DATA_W-1:0]     inport_read_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ERR_W-1:0]      err_count_o,
  output logic [ADDR_W-1:0]     first_err_addr_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int LANES = DATA_W / 32;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BYTES);

  function automatic logic [DATA_W-1:0] pat_full(input logic [ADDR_W-1:0] a, input logic [31:0] p,
                                                 input logic [DATA_W-1:0] s, input logic inv_f);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      r[32*k +: 32] = pat_gen(32'(a), p[7:0], s[32*k +: 32], inv_f);
    end
    return r;
  endfunction

  tg_state_e          state;
  tg_mode_e           mode_q;
  logic [DATA_W-1:0]  seed_q;
  logic [31:0]        idx;
  logic [31:0]        pass_q;

  logic               inv;
  logic               pingpong;
  logic               in_ack_st;
  logic               in_req_st;
  logic               idle_like;
  logic               req_accept;
  logic               last_word;
  logic               last_pass;
  logic [ADDR_W-1:0]  addr_next;
  logic [DATA_W-1:0]  exp_data;
  logic               rd_fail;
  logic               unsolicited;
  logic               to_now;
  logic               err_inc;
  logic [ERR_W-1:0]   err_cnt_nxt;
  logic               ack_expired;

  always_comb begin
    inv         = (mode_q == MODE_SEQ_INV);
    pingpong    = (mode_q == MODE_PINGPONG);
    in_ack_st   = (state == ST_WR_ACK) || (state == ST_RD_ACK);
    in_req_st   = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    idle_like   = (state == ST_IDLE) || (state == ST_DONE);
    req_accept  = in_req_st && inport_accept_i;
    last_word   = (idx == 32'(NUM_WORDS - 1));
    last_pass   = (pass_q == 32'(PASSES - 1));
    addr_next   = inport_addr_o + STRIDE;
    exp_data    = pat_full(inport_addr_o, pass_q, seed_q, inv);
    rd_fail     = (state == ST_RD_ACK) && inport_ack_i &&
                  ((inport_read_data_i != exp_data) || inport_error_i);
    unsolicited = in_req_st && inport_ack_i;
    // An ack in the expiry cycle takes priority over the timeout.
    to_now      = in_ack_st && !inport_ack_i && ack_expired;
    err_inc     = rd_fail || unsolicited || to_now;
    err_cnt_nxt = (err_inc && err_count_o != '1) ? err_count_o + 1'b1 : err_count_o;
  end

  sdram_tg_timeout #(
    .WIDTH (TMO_W),
    .LOAD  (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .start   (req_accept),
    .clear   (idle_like),
    .tick    (in_ack_st),
    .expired (ack_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= ST_IDLE;
      mode_q              <= MODE_SEQ;
      seed_q              <= '0;
      idx                 <= '0;
      pass_q              <= '0;
      inport_wr_o         <= '0;
      inport_rd_o         <= 1'b0;
      inport_addr_o       <= '0;
      inport_write_data_o <= '0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      pass_o              <= 1'b0;
      timeout_o           <= 1'b0;
      err_count_o         <= '0;
      first_err_addr_o    <= '0;
    end else begin
      err_count_o <= err_cnt_nxt;
      if (rd_fail && err_count_o == '0) begin
        first_err_addr_o <= inport_addr_o;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start_i) begin
            mode_q              <= tg_mode_e'(mode_i);
            seed_q              <= seed_i;
            idx                 <= '0;
            pass_q              <= '0;
            err_count_o         <= '0;
            first_err_addr_o    <= '0;
            done_o              <= 1'b0;
            pass_o              <= 1'b0;
            timeout_o           <= 1'b0;
            busy_o              <= 1'b1;
            inport_addr_o       <= BASE_ADDR;
            inport_write_data_o <= pat_full(BASE_ADDR, 32'd0, seed_i, mode_i == MODE_SEQ_INV);
            inport_wr_o         <= '1;
            state               <= ST_WR_REQ;
          end
        end

        ST_WR_REQ: begin
          if (inport_accept_i) begin
            inport_wr_o <= '0;
            state       <= ST_WR_ACK;
          end
        end

        ST_RD_REQ: begin
          if (inport_accept_i) begin
            inport_rd_o <= 1'b0;
            state       <= ST_RD_ACK;
          end
        end

        ST_WR_ACK: begin
          if (inport_ack_i) begin
            if (pingpong) begin
              inport_rd_o <= 1'b1;
              state       <= ST_RD_REQ;
            end else if (!last_word) begin
              idx                 <= idx + 1;
              inport_addr_o       <= addr_next;
              inport_write_data_o <= pat_full(addr_next, pass_q, seed_q, inv);
              inport_wr_o         <= '1;
              state               <= ST_WR_REQ;
            end else begin
              idx           <= '0;
              inport_addr_o <= BASE_ADDR;
              inport_rd_o   <= 1'b1;
              state         <= ST_RD_REQ;
            end
          end else if (to_now) begin
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            pass_o    <= 1'b0;
            state     <= ST_DONE;
          end
        end

        ST_RD_ACK: begin
          if (inport_ack_i) begin
            if (!last_word) begin
              idx           <= idx + 1;
              inport_addr_o <= addr_next;
              if (pingpong) begin
                inport_write_data_o <= pat_full(addr_next, pass_q, seed_q, inv);
                inport_wr_o         <= '1;
                state               <= ST_WR_REQ;
              end else begin
                inport_rd_o <= 1'b1;
                state       <= ST_RD_REQ;
              end
            end else if (!last_pass) begin
              idx                 <= '0;
              pass_q              <= pass_q + 32'd1;
              inport_addr_o       <= BASE_ADDR;
              inport_write_data_o <= pat_full(BASE_ADDR, pass_q + 32'd1, seed_q, inv);
              inport_wr_o         <= '1;
              state               <= ST_WR_REQ;
            end else begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              pass_o <= (err_cnt_nxt == '0);
              state  <= ST_DONE;
            end
          end else if (to_now) begin
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            pass_o    <= 1'b0;
            state     <= ST_DONE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// tb/tb_sdram_traffic_checker.sv - self-checking bench for sdram_traffic_checker
module tb_sdram_traffic_checker;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NW = 4;
  localparam int NP = 2;
  localparam int TO = 16;
  localparam int EW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] seed = '0;
  logic [DW/8-1:0] wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          accept = 1'b0;
  logic          ack = 1'b0;
  logic          rerr = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          busy, done, pass_ok, tmo;
  logic [EW-1:0] errc;
  logic [AW-1:0] ferr;

  sdram_traffic_checker #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR('0),
    .PASSES(NP), .ACK_TIMEOUT(TO), .ERR_W(EW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .seed_i(seed),
    .inport_wr_o(wr), .inport_rd_o(rd), .inport_addr_o(addr), .inport_write_data_o(wdata),
    .inport_accept_i(accept), .inport_ack_i(ack), .inport_error_i(rerr),
    .inport_read_data_i(rdata), .busy_o(busy), .done_o(done), .pass_o(pass_ok),
    .timeout_o(tmo), .err_count_o(errc), .first_err_addr_o(ferr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  req_t exp_q[$];
  req_t obs_q[$];
  int   exp_err;
  logic [31:0] exp_first;
  bit   exp_to;
  bit   exp_pass;

  int cfg_corrupt_rd = -1;
  int cfg_err_rd = -1;
  int cfg_hold_wr = -1;

  int cyc = 0;
  int acc_cyc = 0;
  initial forever @(posedge clk) cyc++;

  function automatic logic [31:0] mpat(input logic [31:0] a, input int p, input logic [31:0] s, input bit inv);
    logic [31:0] v;
    v = a ^ (32'(p) << 24) ^ s;
    return inv ? ~v : v;
  endfunction

  // Expected request stream and final status, derived from mode and the responder's fault plan.
  task automatic build_model(input logic [1:0] m, input logic [31:0] s);
    req_t full[$];
    req_t r;
    int nw = 0;
    int nr = 0;
    bit inv = (m == 2'd2);
    exp_q.delete();
    obs_q.delete();
    exp_err = 0;
    exp_first = 0;
    exp_to = 0;
    for (int p = 0; p < NP; p++) begin
      if (m == 2'd1) begin
        for (int i = 0; i < NW; i++) begin
          r.a = 32'(i * 4); r.d = mpat(r.a, p, s, inv);
          r.is_wr = 1; full.push_back(r);
          r.is_wr = 0; full.push_back(r);
        end
      end else begin
        for (int i = 0; i < NW; i++) begin
          r.a = 32'(i * 4); r.d = mpat(r.a, p, s, inv); r.is_wr = 1; full.push_back(r);
        end
        for (int i = 0; i < NW; i++) begin
          r.a = 32'(i * 4); r.d = mpat(r.a, p, s, inv); r.is_wr = 0; full.push_back(r);
        end
      end
    end
    foreach (full[k]) begin
      exp_q.push_back(full[k]);
      if (full[k].is_wr) begin
        if (nw == cfg_hold_wr) begin
          exp_to = 1;
          exp_err++;
          break;
        end
        nw++;
      end else begin
        if (nr == cfg_corrupt_rd || nr == cfg_err_rd) begin
          if (exp_err == 0) exp_first = full[k].a;
          exp_err++;
        end
        nr++;
      end
    end
    exp_pass = (exp_err == 0);
  endtask

  int rs_age = 0;
  int rs_wait = 0;
  int rs_nw = 0;
  int rs_nr = 0;
  bit rs_hold = 0;
  bit rs_is_rd = 0;
  logic [31:0] rs_addr = 0;
  logic [31:0] mem [logic [31:0]];

  // Responder: accept one cycle after a request appears, ack three cycles after accept.
  initial forever @(negedge clk) begin
    accept = 0; ack = 0; rerr = 0; rdata = '0;
    if (!rst_n) begin
      rs_age = 0; rs_wait = 0;
    end else if (rs_wait > 0) begin
      rs_wait--;
      if (rs_wait == 0 && !rs_hold) begin
        ack = 1;
        if (rs_is_rd) begin
          rdata = mem.exists(rs_addr) ? mem[rs_addr] : 32'h0;
          if (rs_nr == cfg_corrupt_rd) rdata[0] = ~rdata[0];
          if (rs_nr == cfg_err_rd) rerr = 1;
          rs_nr++;
        end
      end
    end else if (wr != 0 || rd) begin
      if (rs_age == 0) begin
        rs_age = 1;
      end else begin
        accept = 1; rs_age = 0; rs_wait = 3; rs_is_rd = rd; rs_addr = addr;
        if (!rd) begin
          mem[addr] = wdata;
          if (rs_nw == cfg_hold_wr) begin
            rs_hold = 1;
            acc_cyc = cyc + 1;
          end
          rs_nw++;
        end
      end
    end
  end

  // Compare process: every visible request must match the head of the expected stream.
  initial begin
    bit prev_vis = 0;
    bit vis;
    req_t cur;
    forever @(negedge clk) begin
      if (!rst_n) begin
        prev_vis = 0;
      end else begin
        vis = (wr != 0) || rd;
        if (vis) begin
          chk("wr_rd_exclusive", (wr != 0) && rd, 0);
          chk("request_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            chk("req_rd", rd, !exp_q[0].is_wr);
            chk("req_wr_be", wr, exp_q[0].is_wr ? 4'hF : 4'h0);
            chk("req_addr", addr, exp_q[0].a);
            if (exp_q[0].is_wr) chk("req_wdata", wdata, exp_q[0].d);
          end
          cur.is_wr = (wr != 0); cur.a = addr; cur.d = wdata;
        end else if (prev_vis) begin
          obs_q.push_back(cur);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        prev_vis = vis;
      end
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [31:0] s, input int corrupt, input int rerr_idx, input int hold);
    #1;
    cfg_corrupt_rd = corrupt; cfg_err_rd = rerr_idx; cfg_hold_wr = hold;
    rs_age = 0; rs_wait = 0; rs_nw = 0; rs_nr = 0; rs_hold = 0;
    mem.delete();
    build_model(m, s);
    @(negedge clk);
    mode = m; seed = s; start = 1;
    @(negedge clk);
    start = 0; mode = 0; seed = '0;
    chk("start_latency_wr", wr, 4'hF);
    chk("start_busy", busy, 1);
  endtask

  task automatic finish_run(input string tag);
    for (int k = 0; k < 3000 && !done; k++) @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pass"}, pass_ok, exp_pass);
    chk({tag, "_err_count"}, errc, exp_err);
    chk({tag, "_first_err"}, ferr, exp_first);
    chk({tag, "_timeout"}, tmo, exp_to);
    chk({tag, "_stream_drained"}, exp_q.size(), 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass_ok, 0);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_err_count"}, errc, 0);
    chk({tag, "_first_err"}, ferr, 0);
  endtask

  bit          pp_wr [6] = '{1, 0, 1, 0, 1, 0};
  logic [31:0] pp_a  [6] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8};

  initial begin
    int k;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    chk("reset_addr", addr, 0);
    chk("reset_wdata", wdata, 0);
    rst_n = 1;

    start_run(2'd0, 32'h0, -1, -1, -1);
    finish_run("seq");
    chk("seq_nreq", obs_q.size(), 16);
    if (obs_q.size() == 16) begin
      chk("seq_w3_addr", obs_q[3].a, 32'hC);
      chk("seq_w3_data", obs_q[3].d, 32'h0000000C);
      chk("seq_r0_is_read", obs_q[4].is_wr, 0);
      chk("seq_p1_w8_data", obs_q[10].d, 32'h01000008);
    end

    start_run(2'd0, 32'h0, 2, -1, -1);
    finish_run("corrupt");
    chk("corrupt_err_lit", errc, 1);
    chk("corrupt_first_lit", ferr, 32'h8);

    start_run(2'd1, 32'hA5A50000, -1, -1, -1);
    finish_run("pingpong");
    chk("pingpong_nreq", obs_q.size(), 16);
    if (obs_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("pingpong_order_type", obs_q[i].is_wr, pp_wr[i]);
        chk("pingpong_order_addr", obs_q[i].a, pp_a[i]);
      end
      chk("pingpong_w4_data", obs_q[2].d, 32'hA5A50004);
    end

    start_run(2'd0, 32'h0, -1, -1, 1);
    k = 0;
    while (!tmo && k < 200) begin @(negedge clk); k++; end
    chk("timeout_seen", tmo, 1);
    chk("timeout_latency", cyc - acc_cyc, TO);
    finish_run("timeout");
    repeat (20) @(negedge clk);
    chk("timeout_no_more_req", obs_q.size(), 2);
    chk("timeout_idle_wr", wr, 0);
    chk("timeout_idle_rd", rd, 0);

    start_run(2'd0, 32'h0F0F0F0F, 0, -1, -1);
    repeat (3) @(negedge clk);
    start = 1; mode = 2'd1; seed = '1;
    @(negedge clk);
    start = 0; mode = 0; seed = '0;
    k = 0;
    while (errc == 0 && k < 300) begin @(negedge clk); k++; end
    chk("busy_start_ignored_err", errc, 1);
    k = 0;
    while (!rd && k < 50) begin @(negedge clk); k++; end
    chk("midrun_rd_seen", rd, 1);
    #2 rst_n = 0;
    #1 chk_cleared("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    start_run(2'd3, 32'h5, -1, -1, -1);
    finish_run("after_reset");

    start_run(2'd2, 32'h12345678, -1, 5, -1);
    finish_run("seqinv");
    chk("seqinv_first_lit", ferr, 32'h4);
    if (obs_q.size() == 16) begin
      chk("seqinv_p0_w4_data", obs_q[1].d, 32'hEDCBA983);
      chk("seqinv_p1_w4_data", obs_q[9].d, 32'hECCBA983);
    end else begin
      chk("seqinv_nreq", obs_q.size(), 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
